// File: rtl/ofm_maxpool_2x2_if.sv
// Stream interface of the 2x2 pooling stage: raster samples in, pooled samples out.
// in_valid qualifies In_OFM with no ready; every valid cycle is accepted and outputs have no backpressure.
interface ofm_maxpool_2x2_if #(
    parameter int DATA_W = 36
);
    logic              in_valid;
    logic [DATA_W-1:0] In_OFM;
    logic              out_valid;
    logic [DATA_W-1:0] Out_Pool;
    logic              frame_done;
    logic              dbg_state;

    modport master (
        output in_valid, In_OFM,
        input  out_valid, Out_Pool, frame_done, dbg_state
    );

    modport slave (
        input  in_valid, In_OFM,
        output out_valid, Out_Pool, frame_done, dbg_state
    );
endinterface

// File: rtl/ofm_maxpool_2x2.sv
// 2x2 stride-1 pooling over a MAP_W x MAP_W raster stream using a one-row line buffer.
// Define POOL_AVG_EN to average the window instead of taking its maximum.
module ofm_maxpool_2x2 #(
    parameter int MAP_W  = 5,
    parameter int DATA_W = 36
) (
    input  logic                clk,
    input  logic                rst_n,
    ofm_maxpool_2x2_if.slave    bus
);
    localparam int CW = $clog2(MAP_W);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_col;
    logic [CW-1:0]     r_row;
    logic [DATA_W-1:0] r_line_buf [MAP_W];
    logic [DATA_W-1:0] r_prev;
    logic [DATA_W-1:0] r_tl;
    logic [DATA_W-1:0] r_out;
    logic              r_out_valid;
    logic              r_frame_done;
    logic              r_last;

    logic              w_accept;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_win;
    logic              w_frame_end;
    logic [DATA_W-1:0] w_tr;
    logic [DATA_W-1:0] w_pool;

    assign w_accept    = bus.in_valid;
    assign w_col_last  = (r_col == CW'(MAP_W - 1));
    assign w_row_last  = (r_row == CW'(MAP_W - 1));
    assign w_frame_end = w_col_last && w_row_last;
    assign w_win       = w_accept && (r_row != '0) && (r_col != '0);
    // Top-right of the window: still row r-1 because this column is not yet overwritten.
    assign w_tr        = r_line_buf[r_col];

`ifdef POOL_AVG_EN
    logic [DATA_W+1:0] w_sum;
    assign w_sum  = {2'b00, r_tl} + {2'b00, w_tr} + {2'b00, r_prev} + {2'b00, bus.In_OFM};
    assign w_pool = w_sum[DATA_W+1:2];
`else
    logic [DATA_W-1:0] w_max_top;
    logic [DATA_W-1:0] w_max_bot;
    always_comb begin
        w_max_top = (r_tl   > w_tr)        ? r_tl   : w_tr;
        w_max_bot = (r_prev > bus.In_OFM)  ? r_prev : bus.In_OFM;
        w_pool    = (w_max_top > w_max_bot) ? w_max_top : w_max_bot;
    end
`endif

    // State only tracks frame activity; acceptance is never gated by it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_state_nxt = RUN;
            RUN:     if (r_last && !bus.in_valid) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_prev       <= '0;
            r_tl         <= '0;
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_last       <= 1'b0;
            for (int i = 0; i < MAP_W; i++) begin
                r_line_buf[i] <= '0;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_last       <= w_accept && w_frame_end;
            r_out_valid  <= w_win;
            r_out        <= w_win ? w_pool : '0;
            r_frame_done <= w_accept && w_frame_end;
            if (w_accept) begin
                r_line_buf[r_col] <= bus.In_OFM;
                r_prev            <= bus.In_OFM;
                r_tl              <= w_tr;
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + CW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.Out_Pool   = r_out;
    assign bus.frame_done = r_frame_done;
    assign bus.dbg_state  = r_state;
endmodule
